gatenet_frame_loader: RTL and testbench

- Sequential front/back harness for the 98-input, 2-output combinational gate-network classifiers.
- Accepts a byte stream carrying one sample per frame and packs it into the 98-bit `in_bits` vector, which drives the network.
- Holds that vector stable for a programmable settle time, then captures the network's `out_bits`.
- Decodes the captured bits to a class index and delivers it on a valid/ready result port.

---
 rtl/gatenet_frame_loader.sv | 147 ++++++++++++++
 tb/tb_gatenet_frame_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gatenet_frame_loader.sv
// Purpose: packs a byte stream into the 98-bit gate-network input, waits, captures and classifies the output.
// Latency: last beat accepted at edge E0, result valid after edge E0+SETTLE_CYC.
// Backpressure: s_ready low from EVAL until the result is taken; m_ready low holds the result indefinitely.
//
// Ports:
//   clk, rst                      - single clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last - input beat stream, LSB-first packing, one sample per frame
//   net_in_bits / net_out_bits    - registered drive into the network / its combinational response
//   m_valid/m_ready               - result handshake
//   m_class/m_raw/m_none/m_err    - lowest set output bit, captured vector, all-zero flag, length error
//   frame_cnt                     - results delivered, saturating
module gatenet_frame_loader #(
    parameter int IN_BITS    = 98,
    parameter int OUT_BITS   = 2,
    parameter int BEAT_W     = 8,
    parameter int SETTLE_CYC = 1,
    parameter int CLS_W      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [BEAT_W-1:0]   s_data,
    input  logic                s_last,
    output logic [IN_BITS-1:0]  net_in_bits,
    input  logic [OUT_BITS-1:0] net_out_bits,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [CLS_W-1:0]    m_class,
    output logic [OUT_BITS-1:0] m_raw,
    output logic                m_none,
    output logic                m_err,
    output logic [15:0]         frame_cnt
);

    localparam int NBEATS = (IN_BITS + BEAT_W - 1) / BEAT_W;
    localparam int BC_W   = $clog2(NBEATS + 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        EVAL  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state;
    logic [BC_W-1:0]    beat_cnt;
    logic [3:0]         settle_cnt;
    logic               err_pend;
    logic [IN_BITS-1:0] vec_nxt;
    logic [CLS_W-1:0]   cls_nxt;
    logic               hs;
    logic               last_slot;

    assign s_ready   = (state == FILL) || (state == DRAIN);
    assign hs        = s_valid && s_ready;
    assign last_slot = (beat_cnt == BC_W'(NBEATS - 1));

    // Merge the current beat into its slot; bits past IN_BITS in the final
    // beat have nowhere to go and are dropped.
    always_comb begin
        vec_nxt = net_in_bits;
        for (int j = 0; j < BEAT_W; j++) begin
            int idx;
            idx = int'(beat_cnt) * BEAT_W + j;
            if (idx < IN_BITS) begin
                vec_nxt[idx] = s_data[j];
            end
        end
    end

    // Lowest set bit wins; scanning downward lets the lowest index overwrite.
    always_comb begin
        cls_nxt = '0;
        for (int i = OUT_BITS - 1; i >= 0; i--) begin
            if (net_out_bits[i]) begin
                cls_nxt = CLS_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            beat_cnt    <= '0;
            settle_cnt  <= '0;
            err_pend    <= 1'b0;
            net_in_bits <= '0;
            m_valid     <= 1'b0;
            m_class     <= '0;
            m_raw       <= '0;
            m_none      <= 1'b0;
            m_err       <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (hs) begin
                        net_in_bits <= vec_nxt;
                        beat_cnt    <= beat_cnt + 1'b1;
                        if (s_last) begin
                            // Early s_last leaves the unreceived slots at zero
                            // (vector was cleared when the previous result left).
                            err_pend   <= !last_slot;
                            settle_cnt <= '0;
                            state      <= EVAL;
                        end else if (last_slot) begin
                            err_pend <= 1'b1;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (hs && s_last) begin
                        settle_cnt <= '0;
                        state      <= EVAL;
                    end
                end
                EVAL: begin
                    if (settle_cnt == 4'(SETTLE_CYC - 1)) begin
                        m_raw   <= net_out_bits;
                        m_class <= cls_nxt;
                        m_none  <= (net_out_bits == '0);
                        m_err   <= err_pend;
                        m_valid <= 1'b1;
                        state   <= HOLD;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid     <= 1'b0;
                        net_in_bits <= '0;
                        beat_cnt    <= '0;
                        if (frame_cnt != 16'hFFFF) begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_gatenet_frame_loader.sv
module tb_gatenet_frame_loader;

    localparam int IN_BITS    = 98;
    localparam int OUT_BITS   = 2;
    localparam int BEAT_W     = 8;
    localparam int SETTLE_CYC = 1;
    localparam int CLS_W      = 1;
    localparam int NBEATS     = 13;

    logic                clk = 1'b0;
    logic                rst;
    logic                s_valid;
    logic                s_ready;
    logic [BEAT_W-1:0]   s_data;
    logic                s_last;
    logic [IN_BITS-1:0]  net_in_bits;
    logic [OUT_BITS-1:0] net_out_bits;
    logic                m_valid;
    logic                m_ready;
    logic [CLS_W-1:0]    m_class;
    logic [OUT_BITS-1:0] m_raw;
    logic                m_none;
    logic                m_err;
    logic [15:0]         frame_cnt;

    always #5 clk = ~clk;

    gatenet_frame_loader #(
        .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .BEAT_W(BEAT_W),
        .SETTLE_CYC(SETTLE_CYC), .CLS_W(CLS_W)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .net_in_bits(net_in_bits), .net_out_bits(net_out_bits),
        .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_raw(m_raw),
        .m_none(m_none), .m_err(m_err), .frame_cnt(frame_cnt)
    );

    // Stand-in network: a small fixed function of the input vector, or a forced value.
    logic          net_force_en;
    logic [1:0]    net_force_val;

    function automatic logic [1:0] net_model(input logic [IN_BITS-1:0] v);
        return {|v[96:40], v[0] ^ v[97]};
    endfunction

    assign net_out_bits = net_force_en ? net_force_val : net_model(net_in_bits);

    typedef struct packed {
        logic [IN_BITS-1:0] vec;
        logic [1:0]         raw;
        logic               cls;
        logic               none;
        logic               err;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [7:0]  beats[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_cnt  = 16'd0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IN_BITS-1:0] pack(input int n);
        logic [IN_BITS-1:0] v;
        v = '0;
        for (int k = 0; k < n && k < NBEATS; k++)
            for (int j = 0; j < BEAT_W; j++)
                if (k * BEAT_W + j < IN_BITS) v[k * BEAT_W + j] = beats[k][j];
        return v;
    endfunction

    task automatic send_beat(input logic [7:0] d, input logic l);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        while (!s_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("s_ready_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame();
        exp_t e;
        e.vec  = pack(beats.size());
        e.raw  = net_force_en ? net_force_val : net_model(e.vec);
        e.cls  = e.raw[0] ? 1'b0 : e.raw[1];
        e.none = (e.raw == 2'b00);
        e.err  = (beats.size() != NBEATS);
        sb.push_back(e);
        for (int k = 0; k < beats.size(); k++)
            send_beat(beats[k], k == beats.size() - 1);
        chk("s_ready_after_last", s_ready, 1'b0);
    endtask

    task automatic get_result();
        int cyc;
        cyc = 0;
        while (!m_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("result_latency", cyc, SETTLE_CYC);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1'b1, 1'b0);
        end else begin
            cur = sb.pop_front();
            chk("m_valid", m_valid, 1'b1);
            chk("net_in_bits", net_in_bits, cur.vec);
            chk("m_raw", m_raw, cur.raw);
            chk("m_class", m_class, cur.cls);
            chk("m_none", m_none, cur.none);
            chk("m_err", m_err, cur.err);
        end
    endtask

    task automatic ack();
        chk("s_ready_in_hold", s_ready, 1'b0);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        if (exp_cnt != 16'hFFFF) exp_cnt++;
        chk("m_valid_after_ack", m_valid, 1'b0);
        chk("frame_cnt", frame_cnt, exp_cnt);
        chk("in_bits_cleared", net_in_bits, '0);
        chk("s_ready_after_ack", s_ready, 1'b1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_m_valid"}, m_valid, 1'b0);
        chk({tag, "_m_class"}, m_class, 1'b0);
        chk({tag, "_m_raw"}, m_raw, 2'b00);
        chk({tag, "_m_none"}, m_none, 1'b0);
        chk({tag, "_m_err"}, m_err, 1'b0);
        chk({tag, "_frame_cnt"}, frame_cnt, 16'd0);
        chk({tag, "_in_bits"}, net_in_bits, '0);
        chk({tag, "_s_ready"}, s_ready, 1'b1);
    endtask

    task automatic load_full_random();
        beats.delete();
        for (int k = 0; k < NBEATS; k++) beats.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        logic [IN_BITS-1:0] v_a;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        m_ready = 1'b0; net_force_en = 1'b0; net_force_val = 2'b00;
        v_a = '0; v_a[0] = 1'b1; v_a[96] = 1'b1; v_a[97] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // Frame A: beat12=0xFF has six bits past the vector end.
        beats.delete();
        beats.push_back(8'h01);
        for (int k = 1; k < 12; k++) beats.push_back(8'h00);
        beats.push_back(8'hFF);
        send_frame();
        get_result();
        chk("frameA_vec_const", net_in_bits, v_a);
        chk("frameA_class", m_class, 1'b1);
        ack();

        // Forced network responses.
        net_force_en = 1'b1;
        net_force_val = 2'b10; load_full_random(); send_frame(); get_result(); ack();
        net_force_val = 2'b11; load_full_random(); send_frame(); get_result(); ack();
        net_force_val = 2'b00; load_full_random(); send_frame(); get_result(); ack();
        net_force_en = 1'b0;

        // Short frame: five beats of 0xAA.
        beats.delete();
        repeat (5) beats.push_back(8'hAA);
        send_frame();
        get_result();
        chk("short_hi_zero", net_in_bits[97:40], '0);
        chk("short_lo", net_in_bits[39:0], 40'hAA_AAAA_AAAA);
        ack();

        // Long frame: 16 beats, the last three dropped.
        beats.delete();
        for (int k = 0; k < 13; k++) beats.push_back(8'(k + 1));
        repeat (3) beats.push_back(8'hEE);
        send_frame();
        get_result();
        ack();

        // Backpressure: hold the result for 20 cycles.
        load_full_random();
        send_frame();
        get_result();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("bp_m_valid", m_valid, 1'b1);
            chk("bp_s_ready", s_ready, 1'b0);
            chk("bp_frame_cnt", frame_cnt, exp_cnt);
            chk("bp_outputs", {m_raw, m_class, m_none, m_err}, {cur.raw, cur.cls, cur.none, cur.err});
            chk("bp_in_bits", net_in_bits, cur.vec);
        end
        ack();

        // Reset while holding a result.
        load_full_random();
        send_frame();
        get_result();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 16'd0;
        check_reset_state("rst_hold");
        load_full_random(); send_frame(); get_result(); ack();
        chk("rst_hold_cnt1", frame_cnt, 16'd1);

        // Reset arriving with beat 6 of a frame.
        load_full_random();
        for (int k = 0; k < 6; k++) send_beat(beats[k], 1'b0);
        s_valid = 1'b1; s_data = beats[6]; s_last = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0;
        exp_cnt = 16'd0;
        check_reset_state("rst_mid");
        load_full_random(); send_frame(); get_result();
        chk("rst_mid_err", m_err, 1'b0);
        ack();
        chk("rst_mid_cnt1", frame_cnt, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
